// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: opcodes, FSM states and the
// layout of a queued command entry.
package alu_pkg;

   localparam int OP_W = 3;

   localparam logic [OP_W-1:0] OP_ADD = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB = 3'b001;
   localparam logic [OP_W-1:0] OP_AND = 3'b010;
   localparam logic [OP_W-1:0] OP_OR  = 3'b011;
   localparam logic [OP_W-1:0] OP_XOR = 3'b100;
   localparam logic [OP_W-1:0] OP_NOT = 3'b101;
   localparam logic [OP_W-1:0] OP_SHL = 3'b110;
   localparam logic [OP_W-1:0] OP_SHR = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Entry layout for the 8-bit datapath; wider builds pack the same fields
   // in the same order {a, b, op, use_acc}.
   typedef struct packed {
      logic [7:0]      a;
      logic [7:0]      b;
      logic [OP_W-1:0] op;
      logic            use_acc;
   } cmd_entry_t;

   function automatic int cmd_entry_bits(input int width);
      return 2 * width + OP_W + 1;
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter.
module alu_cmd_fifo #(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A push while full is refused even if a pop frees a slot this cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/alu_issue.sv
// Registered issue stage in front of the combinational alu: queues commands,
// drives A/B/Opcode from flops and captures Result/Zero/Carry for a consumer.
// Optional accumulator operand enabled by defining ALU_ISSUE_ACC_EN.
module alu_issue
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [2:0]       cmd_op,
   input  logic             cmd_use_acc,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_op,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   input  logic             alu_carry,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_zero,
   output logic             res_carry,
   output logic             busy
);

   localparam int EW = cmd_entry_bits(WIDTH);

   logic [EW-1:0]    push_data;
   logic [EW-1:0]    head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;

   logic [WIDTH-1:0] head_a;
   logic [WIDTH-1:0] head_b;
   logic [2:0]       head_op;
   logic             head_use_acc;
   logic [WIDTH-1:0] a_sel;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [2:0]       alu_op_q, alu_op_d;
   logic             res_valid_q, res_valid_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic             res_zero_q, res_zero_d;
   logic             res_carry_q, res_carry_d;

   assign push_data = {cmd_a, cmd_b, cmd_op, cmd_use_acc};

   alu_cmd_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (cmd_valid),
      .push_data (push_data),
      .pop       (fifo_pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign head_a       = head[EW-1 -: WIDTH];
   assign head_b       = head[EW-1-WIDTH -: WIDTH];
   assign head_op      = head[3:1];
   assign head_use_acc = head[0];

`ifdef ALU_ISSUE_ACC_EN
   logic [WIDTH-1:0] acc_q, acc_d;
   assign a_sel = head_use_acc ? acc_q : head_a;
`else
   // use_acc still travels through the FIFO so the port list never changes.
   logic unused_use_acc;
   assign unused_use_acc = head_use_acc;
   assign a_sel = head_a;
`endif

   always_comb begin
      state_d     = state_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_zero_d  = res_zero_q;
      res_carry_d = res_carry_q;
      fifo_pop    = 1'b0;
`ifdef ALU_ISSUE_ACC_EN
      acc_d       = acc_q;
`endif
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               alu_a_d  = a_sel;
               alu_b_d  = head_b;
               alu_op_d = head_op;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            res_data_d  = alu_result;
            res_zero_d  = alu_zero;
            res_carry_d = alu_carry;
            res_valid_d = 1'b1;
`ifdef ALU_ISSUE_ACC_EN
            acc_d       = alu_result;
`endif
            state_d     = DONE;
         end
         DONE: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               // Back-to-back issue keeps one result every two cycles.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  alu_a_d  = a_sel;
                  alu_b_d  = head_b;
                  alu_op_d = head_op;
                  state_d  = EXEC;
               end else begin
                  state_d  = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= 3'b000;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_zero_q  <= 1'b0;
         res_carry_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_zero_q  <= res_zero_d;
         res_carry_q <= res_carry_d;
      end
   end

`ifdef ALU_ISSUE_ACC_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end
`endif

   assign cmd_ready = !fifo_full;
   assign busy      = (state_q != IDLE) || !fifo_empty;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_op    = alu_op_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_zero  = res_zero_q;
   assign res_carry = res_carry_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural 8-bit ALU closing the loop.
module tb_alu_issue;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_a, cmd_b;
   logic [2:0] cmd_op;
   logic       cmd_use_acc;
   logic [7:0] alu_a, alu_b;
   logic [2:0] alu_op;
   logic [7:0] alu_result;
   logic       alu_zero, alu_carry;
   logic       res_valid, res_ready;
   logic [7:0] res_data;
   logic       res_zero, res_carry;
   logic       busy;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int rr_mode = 0;   // 0: hold low, 1: hold high, 2: random

   typedef struct {
      logic [7:0] d;
      logic       z;
      logic       c;
      int         cyc;
   } res_t;
   res_t got[$];

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      logic [7:0] exp_d;
      logic       exp_z;
      logic       exp_c;
   } vec_t;
   vec_t vec [10];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   alu_issue #(.WIDTH(8), .DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_use_acc(cmd_use_acc),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_zero(res_zero), .res_carry(res_carry),
      .busy(busy)
   );

   // Reference ALU: carry is carry-out for ADD, borrow for SUB, shifted-out bit for shifts.
   logic [8:0] alu_tmp;
   always_comb begin
      alu_tmp = '0;
      case (alu_op)
         OP_ADD:  alu_tmp = {1'b0, alu_a} + {1'b0, alu_b};
         OP_SUB:  alu_tmp = {1'b0, alu_a} - {1'b0, alu_b};
         OP_AND:  alu_tmp = {1'b0, alu_a & alu_b};
         OP_OR:   alu_tmp = {1'b0, alu_a | alu_b};
         OP_XOR:  alu_tmp = {1'b0, alu_a ^ alu_b};
         OP_NOT:  alu_tmp = {1'b0, ~alu_a};
         OP_SHL:  alu_tmp = {alu_a, 1'b0};
         default: alu_tmp = {alu_a[0], 1'b0, alu_a[7:1]};
      endcase
      alu_result = alu_tmp[7:0];
      alu_carry  = alu_tmp[8];
      alu_zero   = (alu_tmp[7:0] == 8'h00);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      case (rr_mode)
         0:       res_ready = 1'b0;
         1:       res_ready = 1'b1;
         default: res_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Result monitor: sampled after all negedge drives settle; the handshake
   // it sees happens at the following rising edge.
   logic       pend = 1'b0;
   logic [9:0] prev;
   always @(negedge clk) begin
      #2;
      if (rst) begin
         pend = 1'b0;
      end else begin
         if (res_valid && pend)
            check("res_stable", {22'd0, res_data, res_zero, res_carry}, {22'd0, prev});
         if (res_valid && res_ready) begin
            got.push_back('{res_data, res_zero, res_carry, cyc});
            $display("[TB] result data=0x%02h zero=%0b carry=%0b cycle=%0d",
                     res_data, res_zero, res_carry, cyc);
            pend = 1'b0;
         end else if (res_valid) begin
            pend = 1'b1;
            prev = {res_data, res_zero, res_carry};
         end else begin
            pend = 1'b0;
         end
      end
   end

   task automatic push_cmd(input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] op, input logic ua);
      int n = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; cmd_use_acc = ua;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) check("push_timeout", 32'd1, 32'd0);
      @(posedge clk);
      $display("[TB] push a=0x%02h b=0x%02h op=%0d use_acc=%0b", a, b, op, ua);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_results(input int want);
      int n = 0;
      while (got.size() < want && n < 2000) begin
         @(negedge clk);
         #3;
         n++;
      end
      check("result_count", got.size(), want);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      #3;
      while ((busy || res_valid) && n < 500) begin
         @(negedge clk);
         #3;
         n++;
      end
      if (busy || res_valid) check("idle_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int accepted;
      logic [7:0] exp_acc;

      vec[0] = '{8'd12,  8'd5,  OP_ADD, 8'd17,  1'b0, 1'b0};
      vec[1] = '{8'hFF,  8'h01, OP_ADD, 8'h00,  1'b1, 1'b1};
      vec[2] = '{8'h00,  8'h00, OP_ADD, 8'h00,  1'b1, 1'b0};
      vec[3] = '{8'd10,  8'd3,  OP_SUB, 8'd7,   1'b0, 1'b0};
      vec[4] = '{8'hCC,  8'hAA, OP_AND, 8'h88,  1'b0, 1'b0};
      vec[5] = '{8'hCC,  8'hAA, OP_OR,  8'hEE,  1'b0, 1'b0};
      vec[6] = '{8'hCC,  8'hAA, OP_XOR, 8'h66,  1'b0, 1'b0};
      vec[7] = '{8'hCC,  8'h55, OP_NOT, 8'h33,  1'b0, 1'b0};
      vec[8] = '{8'h0C,  8'h00, OP_SHL, 8'h18,  1'b0, 1'b0};
      vec[9] = '{8'h81,  8'h00, OP_SHR, 8'h40,  1'b0, 1'b1};

      rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_use_acc = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_res_valid", res_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_alu_op", alu_op, 0);
      check("rst_res_flags", {res_data, res_zero, res_carry}, 0);
      rst = 1'b0;
      rr_mode = 1;

      // Latency: push at edge N, operands loaded at N+1, result valid after N+2.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_a = 8'd12; cmd_b = 8'd5; cmd_op = OP_ADD; cmd_use_acc = 1'b0;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      check("lat_n_busy", busy, 1);
      check("lat_n_valid", res_valid, 0);
      @(posedge clk); #1;
      check("lat_n1_valid", res_valid, 0);
      check("lat_n1_alu_ab_op", {alu_a, alu_b, alu_op}, {8'd12, 8'd5, OP_ADD});
      @(posedge clk); #1;
      check("lat_n2_valid", res_valid, 1);
      check("lat_n2_data", {res_data, res_zero, res_carry}, {8'd17, 1'b0, 1'b0});
      wait_idle();
      got.delete();

      // Table of operations with random result backpressure.
      rr_mode = 2;
      foreach (vec[i]) push_cmd(vec[i].a, vec[i].b, vec[i].op, 1'b0);
      wait_results(10);
      foreach (vec[i]) begin
         if (i < got.size()) begin
            check($sformatf("vec%0d_data", i), got[i].d, vec[i].exp_d);
            check($sformatf("vec%0d_zero", i), got[i].z, vec[i].exp_z);
            check($sformatf("vec%0d_carry", i), got[i].c, vec[i].exp_c);
         end
      end
      rr_mode = 1;
      wait_idle();
      got.delete();

      // Backpressure: DEPTH+1 commands accepted while res_ready is low.
      rr_mode = 0;
      accepted = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         cmd_valid = 1'b1; cmd_a = 8'(accepted * 10 + 1); cmd_b = 8'd1;
         cmd_op = OP_ADD; cmd_use_acc = 1'b0;
         #1;
         if (cmd_ready) accepted++;
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      check("bp_accepted", accepted, 5);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_busy", busy, 1);
      rr_mode = 1;
      wait_results(5);
      for (int i = 0; i < 5; i++) begin
         if (i < got.size()) begin
            check($sformatf("bp%0d_data", i), got[i].d, 8'(i * 10 + 2));
            if (i > 0) check($sformatf("bp%0d_gap", i), got[i].cyc - got[i-1].cyc, 2);
         end
      end
      wait_idle();
      got.delete();

      // Accumulator operand.
      push_cmd(8'd3, 8'd4, OP_ADD, 1'b0);
      push_cmd(8'd0, 8'd10, OP_ADD, 1'b1);
      wait_results(2);
`ifdef ALU_ISSUE_ACC_EN
      exp_acc = 8'd17;
`else
      exp_acc = 8'd10;
`endif
      if (got.size() >= 2) begin
         check("acc_first", got[0].d, 8'd7);
         check("acc_second", got[1].d, exp_acc);
      end
      wait_idle();
      got.delete();

      // Reset while EXEC with three commands still queued.
      rr_mode = 0;
      for (int i = 0; i < 5; i++) push_cmd(8'(i + 100), 8'd1, OP_ADD, 1'b0);
      check("rstx_full", cmd_ready, 0);
      rr_mode = 1;
      wait_results(1);
      @(posedge clk);          // handshake edge: FSM enters EXEC
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      check("rstx_res_valid", res_valid, 0);
      check("rstx_cmd_ready", cmd_ready, 1);
      check("rstx_busy", busy, 0);
      rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("rstx_no_more_results", got.size(), 1);
      check("rstx_still_idle", {busy, res_valid}, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule
